placar_jogo: RTL and testbench
==============================

Name: placar_jogo

Overview:
- Sequential score and game-state keeper that replaces the combinational point count currently wired into the 7-segment path.
- Consumes the per-enemy alive vector and the loss flag from the entities block.
- Accumulates a 2-digit BCD score across waves, tracks a high score, and detects wave clears and game over.
- Feeds BCD digits and a blink-blank control to the cb7s display decoders.

Parameters:
- N_INIMIGOS, 5, number of enemies (width of the alive vector).
- PONTOS_POR_INIMIGO, 1, BCD points added per destroyed enemy (1..9).
- BLINK_DIV, 25000000, CLOCK_50 cycles per half-period of the game-over blink.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high; clears all state including the high score.
- pausa  input  1  level; while high, kills are not scored and the state is frozen.
- reiniciar  input  1  synchronous one-cycle pulse; starts a new game and keeps the high score.
- inimigo_vivo_array  input  N_INIMIGOS  bit i high = enemy i alive.
- perdeu  input  1  level from entities; high = player lost.
- pontos_uni  output  4  BCD units digit of the score.
- pontos_dez  output  4  BCD tens digit of the score.
- recorde_uni  output  4  BCD units digit of the high score.
- recorde_dez  output  4  BCD tens digit of the high score.
- onda_completa  output  1  one-cycle pulse when the wave is cleared.
- fim_de_jogo  output  1  high while in state FIM.
- apagar  output  1  display blank request; toggles in FIM, 0 otherwise.

Behaviour:
- Clock and reset: single clock CLOCK_50. Reset is asynchronous and active-high.
- Reset values: all outputs 0; vivo_q=0; state JOGANDO; blink counter 0.
- Kill detection:
  - vivo_q <= inimigo_vivo_array every cycle, regardless of state or pausa.
  - kills = vivo_q & ~inimigo_vivo_array (falling edges only). k = popcount(kills), range 0..N.
  - Rising edges (enemy respawn) are never scored.
  - Because vivo_q resets to 0, the first cycle after reset scores nothing.
- Score:
  - Add k*PONTOS_POR_INIMIGO in BCD, registered, one-cycle latency from the edge.
  - Only in JOGANDO or ONDA_LIMPA with pausa=0.
  - Saturates at 99; never wraps.
  - Kills while pausa=1 or in FIM are discarded.
- State machine:
  - JOGANDO:
    - If inimigo_vivo_array==0 and vivo_q!=0 and pausa=0: pulse onda_completa for 1 cycle and go to ONDA_LIMPA. Kills in that same cycle are still scored.
    - If perdeu=1 and pausa=0: go to FIM. Kills in the same cycle are scored first.
    - perdeu has priority over the wave-clear transition.
  - ONDA_LIMPA:
    - Any alive bit becomes 1: go to JOGANDO.
    - perdeu=1: go to FIM.
    - No further onda_completa pulses until JOGANDO is re-entered.
  - FIM:
    - fim_de_jogo=1.
    - On the first FIM cycle, if score > recorde then recorde <= score. recorde reflects the final score 2 cycles after perdeu is sampled.
    - The blink counter runs; apagar toggles every BLINK_DIV cycles, starting at 0 on entry.
    - Leaves only via reiniciar or reset.
- reiniciar (any state):
  - Next cycle: score=0, state JOGANDO, apagar=0, blink counter=0, onda_completa=0.
  - recorde is kept.
  - reiniciar wins over simultaneous perdeu, kills, and wave clear.
- pausa during FIM: the blink counter keeps running (display only).
- perdeu held high after reiniciar: FIM is re-entered the following cycle. This is intended; entities owns clearing perdeu.
- Reset mid-operation: immediate asynchronous clear of everything, including recorde.

Test Plan:
1. Reset, then drive alive=11111. Drop bit0, then bits 1 and 2 together on a later cycle → score 01, then 03. onda_completa stays 0.
2. From score 03, drop the remaining two bits in one cycle → score 05. onda_completa pulses for exactly 1 cycle; the FSM stays in ONDA_LIMPA. Set alive=11111 → state JOGANDO, score still 05, no pulse.
3. With pausa=1, drop bit3 → score unchanged. Set pausa=0 with bit3 still 0 → score unchanged, since the edge was consumed.
4. Preload score 97 via repeated waves, then kill 5 at once → score 99. Further kills keep it at 99.
5. Score 12 with recorde 00. Drop one bit and raise perdeu in the same cycle → score 13, fim_de_jogo=1, recorde 13 by cycle +2. Use BLINK_DIV=4 in the bench → apagar toggles every 4 cycles.
6. In FIM, pulse reiniciar together with perdeu=1 → score 00, JOGANDO for 1 cycle, recorde 13 kept. Then assert reset → recorde 00 and all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/placar_jogo_if.sv
// placar_jogo_if: game inputs from the entities block and score/display outputs to the decoders
interface placar_jogo_if #(parameter int N_INIMIGOS = 5);
  logic                  pausa;
  logic                  reiniciar;
  logic [N_INIMIGOS-1:0] inimigo_vivo_array;
  logic                  perdeu;
  logic [3:0]            pontos_uni;
  logic [3:0]            pontos_dez;
  logic [3:0]            recorde_uni;
  logic [3:0]            recorde_dez;
  logic                  onda_completa;
  logic                  fim_de_jogo;
  logic                  apagar;
  modport master (
    output pausa, reiniciar, inimigo_vivo_array, perdeu,
    input  pontos_uni, pontos_dez, recorde_uni, recorde_dez, onda_completa, fim_de_jogo, apagar
  );
  modport slave (
    input  pausa, reiniciar, inimigo_vivo_array, perdeu,
    output pontos_uni, pontos_dez, recorde_uni, recorde_dez, onda_completa, fim_de_jogo, apagar
  );
endinterface

// File: rtl/placar_jogo.sv
// placar_jogo: saturating BCD score and high score with wave-clear / game-over FSM and blink control
module placar_jogo #(
  parameter int N_INIMIGOS         = 5,
  parameter int PONTOS_POR_INIMIGO = 1,
  parameter int BLINK_DIV          = 25000000
) (
  input logic         CLOCK_50,
  input logic         reset,
  placar_jogo_if.slave bus
);
  localparam int CW = $clog2(BLINK_DIV + 1);
  typedef enum logic [1:0] {JOGANDO, ONDA_LIMPA, FIM} estado_t;
  estado_t               estado_q, estado_d;
  logic [N_INIMIGOS-1:0] vivo_q, kills;
  logic [3:0]            uni_q, uni_d, dez_q, dez_d, rec_uni_q, rec_uni_d, rec_dez_q, rec_dez_d;
  logic                  onda_q, onda_d, apagar_q, apagar_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           k, soma, sat;
  logic                  limpou, pontua, atualiza_rec, em_fim, fecha;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado_q  <= JOGANDO;
      vivo_q    <= '0;
      uni_q     <= '0;
      dez_q     <= '0;
      rec_uni_q <= '0;
      rec_dez_q <= '0;
      onda_q    <= 1'b0;
      apagar_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      vivo_q    <= bus.inimigo_vivo_array;
      uni_q     <= uni_d;
      dez_q     <= dez_d;
      rec_uni_q <= rec_uni_d;
      rec_dez_q <= rec_dez_d;
      onda_q    <= onda_d;
      apagar_q  <= apagar_d;
      cnt_q     <= cnt_d;
    end
  end
  assign limpou = estado_q == JOGANDO && bus.inimigo_vivo_array == '0 && vivo_q != '0;
  // perdeu outranks the wave clear; reiniciar outranks everything
  always_comb begin
    estado_d = estado_q;
    if (bus.reiniciar) estado_d = JOGANDO;
    else if (estado_q != FIM && !bus.pausa) begin
      if (bus.perdeu) estado_d = FIM;
      else if (limpou) estado_d = ONDA_LIMPA;
      else if (estado_q == ONDA_LIMPA && |bus.inimigo_vivo_array) estado_d = JOGANDO;
    end
  end
  always_comb begin
    kills = vivo_q & ~bus.inimigo_vivo_array;
    k = '0;
    for (int i = 0; i < N_INIMIGOS; i++) k = k + 16'(kills[i]);
    soma = 16'(dez_q) * 16'd10 + 16'(uni_q) + k * 16'(PONTOS_POR_INIMIGO);
    sat = soma > 16'd99 ? 16'd99 : soma;
    pontua = estado_q != FIM && !bus.pausa;
    uni_d = bus.reiniciar ? 4'd0 : pontua ? 4'(sat % 16'd10) : uni_q;
    dez_d = bus.reiniciar ? 4'd0 : pontua ? 4'(sat / 16'd10) : dez_q;
    // score is frozen in FIM, so checking every FIM cycle equals checking the first one
    atualiza_rec = estado_q == FIM && {dez_q, uni_q} > {rec_dez_q, rec_uni_q};
    rec_uni_d = atualiza_rec ? uni_q : rec_uni_q;
    rec_dez_d = atualiza_rec ? dez_q : rec_dez_q;
    em_fim = estado_q == FIM && !bus.reiniciar;
    fecha = cnt_q == CW'(BLINK_DIV - 1);
    cnt_d = (!em_fim || fecha) ? '0 : cnt_q + CW'(1);
    apagar_d = em_fim && (apagar_q ^ fecha);
    onda_d = estado_q == JOGANDO && estado_d == ONDA_LIMPA;
  end
  assign bus.pontos_uni    = uni_q;
  assign bus.pontos_dez    = dez_q;
  assign bus.recorde_uni   = rec_uni_q;
  assign bus.recorde_dez   = rec_dez_q;
  assign bus.onda_completa = onda_q;
  assign bus.fim_de_jogo   = estado_q == FIM;
  assign bus.apagar        = apagar_q;
endmodule

// File: tb/tb_placar_jogo.sv
// tb_placar_jogo: directed plan scenarios plus random play against a score/phase reference model
module tb_placar_jogo;
  localparam int BD = 4;
  localparam int PTS = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int m_score, m_rec, m_fimcyc, m_phase;
  bit m_onda;
  logic [4:0] m_prev;
  placar_jogo_if #(.N_INIMIGOS(5)) bus ();
  placar_jogo #(.N_INIMIGOS(5), .PONTOS_POR_INIMIGO(PTS), .BLINK_DIV(BD)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int score();
    return int'(bus.pontos_dez) * 10 + int'(bus.pontos_uni);
  endfunction
  task automatic model_reset();
    m_score = 0; m_rec = 0; m_fimcyc = 0; m_phase = 0; m_onda = 0; m_prev = '0;
  endtask
  // phase: 0 playing, 1 wave cleared, 2 game over
  task automatic model_step(input logic [4:0] a, input bit per, input bit pau, input bit rei);
    int kills;
    int old;
    kills = $countones(m_prev & ~a);
    old = m_phase;
    m_onda = 0;
    if (m_phase == 2 && m_score > m_rec) m_rec = m_score;
    if (rei) begin
      m_score = 0;
      m_phase = 0;
    end else if (m_phase != 2 && !pau) begin
      m_score = (m_score + kills * PTS > 99) ? 99 : m_score + kills * PTS;
      if (per) m_phase = 2;
      else if (m_phase == 0 && a == 0 && m_prev != 0) begin
        m_phase = 1;
        m_onda = 1;
      end else if (m_phase == 1 && a != 0) m_phase = 0;
    end
    m_fimcyc = (old == 2 && m_phase == 2) ? m_fimcyc + 1 : 0;
    m_prev = a;
  endtask
  task automatic check_all();
    chk("uni", bus.pontos_uni, m_score % 10);
    chk("dez", bus.pontos_dez, m_score / 10);
    chk("rec_uni", bus.recorde_uni, m_rec % 10);
    chk("rec_dez", bus.recorde_dez, m_rec / 10);
    chk("onda", bus.onda_completa, m_onda);
    chk("fim", bus.fim_de_jogo, m_phase == 2);
    chk("apagar", bus.apagar, m_phase == 2 ? (m_fimcyc / BD) % 2 : 0);
  endtask
  task automatic cycle(input logic [4:0] a, input bit per = 0, input bit pau = 0, input bit rei = 0);
    bus.inimigo_vivo_array = a;
    bus.perdeu = per;
    bus.pausa = pau;
    bus.reiniciar = rei;
    @(posedge clk);
    model_step(a, per, pau, rei);
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_async_rec", {bus.recorde_dez, bus.recorde_uni}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic [4:0] a;
    bus.inimigo_vivo_array = '0;
    bus.perdeu = 1'b0;
    bus.pausa = 1'b0;
    bus.reiniciar = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;
    cycle(5'b11111);
    chk("t1_first", score(), 0);
    cycle(5'b11110);
    chk("t1_s1", score(), 1);
    cycle(5'b11000);
    chk("t1_s3", score(), 3);
    cycle(5'b00000);
    chk("t2_s5", score(), 5);
    chk("t2_pulse", bus.onda_completa, 1);
    cycle(5'b00000);
    chk("t2_pulse_end", bus.onda_completa, 0);
    cycle(5'b11111);
    chk("t2_back", score(), 5);
    cycle(5'b10111, 0, 1);
    chk("t3_paused", score(), 5);
    cycle(5'b10111);
    chk("t3_consumed", score(), 5);
    cycle(5'b10111, 0, 0, 1);
    for (int w = 0; w < 19; w++) begin
      cycle(5'b11111);
      cycle(5'b00000);
    end
    chk("t4_s95", score(), 95);
    cycle(5'b11111);
    cycle(5'b11100);
    chk("t4_s97", score(), 97);
    cycle(5'b11111);
    cycle(5'b00000);
    chk("t4_sat", score(), 99);
    cycle(5'b11111);
    cycle(5'b11110);
    chk("t4_sat_hold", score(), 99);
    do_reset();
    cycle(5'b11111);
    cycle(5'b00000);
    cycle(5'b11111);
    cycle(5'b00000);
    cycle(5'b11111);
    cycle(5'b11100);
    chk("t5_s12", score(), 12);
    cycle(5'b11000, 1);
    chk("t5_s13", score(), 13);
    chk("t5_fim", bus.fim_de_jogo, 1);
    cycle(5'b11000, 1);
    chk("t5_rec13", {bus.recorde_dez, bus.recorde_uni}, 8'h13);
    cycle(5'b11000, 1);
    cycle(5'b10000, 1, 1);
    chk("t5_blink_off", bus.apagar, 0);
    cycle(5'b10000, 1);
    chk("t5_blink_on", bus.apagar, 1);
    repeat (3) cycle(5'b10000, 1);
    chk("t5_blink_still", bus.apagar, 1);
    cycle(5'b10000, 1);
    chk("t5_blink_off2", bus.apagar, 0);
    cycle(5'b10000, 1, 0, 1);
    chk("t6_s0", score(), 0);
    chk("t6_play", bus.fim_de_jogo, 0);
    chk("t6_rec_kept", {bus.recorde_dez, bus.recorde_uni}, 8'h13);
    cycle(5'b10000, 1);
    chk("t6_refim", bus.fim_de_jogo, 1);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      a = bus.inimigo_vivo_array;
      if (r < 15) a = 5'b11111;
      else if (r < 60) a = a & 5'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle(a, $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
